// File: rtl/guess_checker.sv
// guess_checker
//   Consumer side of the number generator interface. Requests a fresh value
//   from the generator, latches it as the round target, judges the player's
//   guess on a submit press (or a round timeout), and reports the result,
//   score and remaining lives to the display logic.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       level; begins a game when sampled in IDLE or GAME_OVER
//   rnd_value   generator result
//   gen_enable  one-cycle request to the generator
//   guess       player switches
//   submit      debounced button level; rising edge detected here
//   target      current round target
//   correct     high while showing a hit
//   wrong       high while showing a miss or timeout
//   score       hits this game, saturating
//   lives_left  remaining lives
//   game_over   high in GAME_OVER
//   busy        high in every state except IDLE and GAME_OVER

module guess_checker #(
  parameter int WIDTH          = 4,
  parameter int TIMEOUT_CYCLES = 50,
  parameter int SHOW_CYCLES    = 8,
  parameter int LIVES          = 3,
  parameter int SCORE_W        = 8,
  parameter int MAX_RETRY      = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   rnd_value,
  output logic               gen_enable,
  input  logic [WIDTH-1:0]   guess,
  input  logic               submit,
  output logic [WIDTH-1:0]   target,
  output logic               correct,
  output logic               wrong,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives_left,
  output logic               game_over,
  output logic               busy
);

  // One timer serves both the round timeout and the result display.
  localparam int TMAX = (TIMEOUT_CYCLES > SHOW_CYCLES) ? TIMEOUT_CYCLES : SHOW_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]      SHOW_LAST    = TW'(SHOW_CYCLES - 1);
  localparam logic [RW-1:0]      RETRY_MAX    = RW'(MAX_RETRY);
  localparam logic [3:0]         LIVES_INIT   = 4'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_SAT    = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WAIT,
    S_SHOW,
    S_GAME_OVER
  } state_t;

  state_t           state;
  logic             submit_q;
  logic [RW-1:0]    retry;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] prev_target;
  logic             first_round;
  logic             submit_edge;

  // submit_q is updated in every state, so a press held across entry to
  // WAIT never looks like a fresh edge there.
  assign submit_edge = submit & ~submit_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      gen_enable  <= 1'b0;
      target      <= '0;
      correct     <= 1'b0;
      wrong       <= 1'b0;
      score       <= '0;
      lives_left  <= LIVES_INIT;
      game_over   <= 1'b0;
      busy        <= 1'b0;
      submit_q    <= 1'b0;
      retry       <= '0;
      timer       <= '0;
      prev_target <= '0;
      first_round <= 1'b1;
    end else begin
      submit_q <= submit;

      case (state)
        S_IDLE, S_GAME_OVER: begin
          if (start) begin
            state       <= S_FETCH;
            gen_enable  <= 1'b1;
            busy        <= 1'b1;
            game_over   <= 1'b0;
            score       <= '0;
            lives_left  <= LIVES_INIT;
            first_round <= 1'b1;
            retry       <= '0;
          end
        end

        S_FETCH: begin
          gen_enable <= 1'b0;
          state      <= S_LATCH;
        end

        S_LATCH: begin
          // A repeat of the last target is re-requested a bounded number of
          // times; after that the repeat is accepted.
          if (rnd_value == prev_target && !first_round && retry < RETRY_MAX) begin
            retry      <= retry + RW'(1);
            gen_enable <= 1'b1;
            state      <= S_FETCH;
          end else begin
            target      <= rnd_value;
            prev_target <= rnd_value;
            retry       <= '0;
            first_round <= 1'b0;
            timer       <= '0;
            state       <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A press in the last timeout cycle still gets judged.
          if (submit_edge || timer == TIMEOUT_LAST) begin
            timer <= '0;
            state <= S_SHOW;
            if (submit_edge && guess == target) begin
              correct <= 1'b1;
              if (score != SCORE_SAT) score <= score + SCORE_W'(1);
            end else begin
              wrong <= 1'b1;
              if (lives_left != 4'd0) lives_left <= lives_left - 4'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_SHOW: begin
          if (timer == SHOW_LAST) begin
            timer   <= '0;
            correct <= 1'b0;
            wrong   <= 1'b0;
            if (lives_left == 4'd0) begin
              state     <= S_GAME_OVER;
              game_over <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state      <= S_FETCH;
              gen_enable <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          state      <= S_IDLE;
          gen_enable <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
